// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory arbiter.
//   ADDR_W / DATA_W : byte-address and data widths (9, 32)
//   WID_*           : access-width codes carried on req_width / mem_width_sel
//   state_t         : response-slot state (IDLE = nothing due, RESP = due now)
//   req_legal()     : legality check for a request (width code, store/unsigned
//                     combination, natural alignment)
package dmem_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  localparam logic [2:0] WID_B  = 3'b000;
  localparam logic [2:0] WID_H  = 3'b001;
  localparam logic [2:0] WID_W  = 3'b010;
  localparam logic [2:0] WID_BU = 3'b011;
  localparam logic [2:0] WID_HU = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Only the two low address bits matter for alignment; upper bits are
  // passed straight to memory without any range check.
  function automatic logic req_legal(input logic       we,
                                     input logic [2:0] width,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (width)
      WID_B:   ok = 1'b1;
      WID_BU:  ok = ~we;                       // unsigned codes are load-only
      WID_H:   ok = ~addr_lo[0];
      WID_HU:  ok = ~we & ~addr_lo[0];
      WID_W:   ok = (addr_lo == 2'b00);
      default: ok = 1'b0;                      // 101..111 are undefined
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst : clock and synchronous active-high reset
//   req[1:0] : request lines
//   advance  : a grant was taken this cycle; move the last-grant pointer
//   gnt[1:0] : one-hot grant (combinational from req and pointer)
// After reset the pointer names port 1, so port 0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_last;   // index of the port granted most recently

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = r_last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (advance) begin
      r_last <= gnt[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between two requesters.
//   clk, rst            : clock, synchronous active-high reset
//   pN_req_*            : request channel (valid/ready, we, width, addr, wdata)
//   pN_resp_*           : one-cycle response pulse with rdata and err
//   mem_we/mem_re       : memory strobes, driven in the accept cycle
//   mem_width_sel/addr/wdata : memory command fields; hold when idle
//   mem_rdata           : load result, valid the cycle after mem_re
// Every accepted request is answered exactly one cycle later. Illegal
// requests are accepted but never reach memory; they answer with err=1.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [2:0]        p0_req_width,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_resp_valid,
  output logic [DATA_W-1:0] p0_resp_rdata,
  output logic              p0_resp_err,

  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [2:0]        p1_req_width,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_resp_valid,
  output logic [DATA_W-1:0] p1_resp_rdata,
  output logic              p1_resp_err,

  output logic              mem_we,
  output logic              mem_re,
  output logic [2:0]        mem_width_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_accept;
  logic              w_sel;
  logic              w_we;
  logic [2:0]        w_width;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_legal;
  logic              w_issue;
  logic              w_resp_due;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_slot_port;
  logic              r_slot_load;
  logic              r_slot_err;
  logic [2:0]        r_mem_width;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  // Masking requests during reset keeps ready low and the pointer frozen.
  assign w_req = {p1_req_valid, p0_req_valid} & {2{~rst}};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_accept),
    .gnt     (w_gnt)
  );

  assign w_accept     = |w_gnt;
  assign w_sel        = w_gnt[1];
  assign p0_req_ready = w_gnt[0];
  assign p1_req_ready = w_gnt[1];

  assign w_we    = w_sel ? p1_req_we    : p0_req_we;
  assign w_width = w_sel ? p1_req_width : p0_req_width;
  assign w_addr  = w_sel ? p1_req_addr  : p0_req_addr;
  assign w_wdata = w_sel ? p1_req_wdata : p0_req_wdata;

  assign w_legal = req_legal(w_we, w_width, w_addr[1:0]);
  assign w_issue = w_accept & w_legal;

  assign mem_we = w_issue & w_we;
  assign mem_re = w_issue & ~w_we;

  // Command fields follow the granted port only when something is issued;
  // otherwise the last issued command is held. Forced to 0 while in reset
  // so the very first reset cycle is already clean.
  assign mem_width_sel = rst ? 3'b000         : (w_issue ? w_width : r_mem_width);
  assign mem_addr      = rst ? '0             : (w_issue ? w_addr  : r_mem_addr);
  assign mem_wdata     = rst ? '0             : (w_issue ? w_wdata : r_mem_wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_slot_port <= 1'b0;
      r_slot_load <= 1'b0;
      r_slot_err  <= 1'b0;
      r_mem_width <= 3'b000;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_slot_port <= w_sel;
        r_slot_load <= ~w_we;
        r_slot_err  <= ~w_legal;
      end
      if (w_issue) begin
        r_mem_width <= w_width;
        r_mem_addr  <= w_addr;
        r_mem_wdata <= w_wdata;
      end
    end
  end

  // Next state and response outputs. A response due this cycle never blocks
  // a new accept, so RESP simply stays RESP when another request lands.
  always_comb begin
    w_state_next  = r_state;
    p0_resp_valid = 1'b0;
    p0_resp_err   = 1'b0;
    p0_resp_rdata = '0;
    p1_resp_valid = 1'b0;
    p1_resp_err   = 1'b0;
    p1_resp_rdata = '0;

    case (r_state)
      IDLE:    w_state_next = w_accept ? RESP : IDLE;
      RESP:    w_state_next = w_accept ? RESP : IDLE;
      default: w_state_next = IDLE;
    endcase

    w_resp_due = (r_state == RESP) & ~rst;
    if (w_resp_due) begin
      if (r_slot_port) begin
        p1_resp_valid = 1'b1;
        p1_resp_err   = r_slot_err;
        p1_resp_rdata = (r_slot_load & ~r_slot_err) ? mem_rdata : '0;
      end else begin
        p0_resp_valid = 1'b1;
        p0_resp_err   = r_slot_err;
        p0_resp_rdata = (r_slot_load & ~r_slot_err) ? mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, table-driven bench for dmem_arbiter with a
// little-endian byte-addressed memory model (512 bytes, registered read).
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req_valid, p0_req_ready, p0_req_we;
  logic [2:0]  p0_req_width;
  logic [8:0]  p0_req_addr;
  logic [31:0] p0_req_wdata;
  logic        p0_resp_valid, p0_resp_err;
  logic [31:0] p0_resp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we;
  logic [2:0]  p1_req_width;
  logic [8:0]  p1_req_addr;
  logic [31:0] p1_req_wdata;
  logic        p1_resp_valid, p1_resp_err;
  logic [31:0] p1_resp_rdata;
  logic        mem_we, mem_re;
  logic [2:0]  mem_width_sel;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_width(p0_req_width), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_width(p1_req_width), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_width_sel(mem_width_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem_bytes [0:511] = '{default: 8'h00};

  function automatic logic [31:0] mem_load(input logic [8:0] a, input logic [2:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem_bytes[a];
    b1 = mem_bytes[9'(a + 9'd1)];
    b2 = mem_bytes[9'(a + 9'd2)];
    b3 = mem_bytes[9'(a + 9'd3)];
    case (w)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b011:  return {24'h0, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem_bytes[mem_addr] <= mem_wdata[7:0];
      if (mem_width_sel != 3'b000 && mem_width_sel != 3'b011)
        mem_bytes[9'(mem_addr + 9'd1)] <= mem_wdata[15:8];
      if (mem_width_sel == 3'b010) begin
        mem_bytes[9'(mem_addr + 9'd2)] <= mem_wdata[23:16];
        mem_bytes[9'(mem_addr + 9'd3)] <= mem_wdata[31:24];
      end
    end
    if (mem_re) mem_rdata <= mem_load(mem_addr, mem_width_sel);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v0; logic we0; logic [2:0] w0; logic [8:0] a0; logic [31:0] d0;
    logic        v1; logic we1; logic [2:0] w1; logic [8:0] a1; logic [31:0] d1;
    logic [1:0]  rdy; logic mwe; logic mre; logic [8:0] maddr;
    logic [1:0]  rv; logic [1:0] err; logic [31:0] rd0; logic [31:0] rd1;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic v0, input logic we0, input logic [2:0] w0, input logic [8:0] a0, input logic [31:0] d0,
                     input logic v1, input logic we1, input logic [2:0] w1, input logic [8:0] a1, input logic [31:0] d1,
                     input logic [1:0] rdy, input logic mwe, input logic mre, input logic [8:0] maddr,
                     input logic [1:0] rv, input logic [1:0] err, input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.rdy = rdy; v.mwe = mwe; v.mre = mre; v.maddr = maddr;
    v.rv = rv; v.err = err; v.rd0 = rd0; v.rd1 = rd1;
    vt.push_back(v);
  endtask

  task automatic drive_p0(input logic v, input logic we, input logic [2:0] w, input logic [8:0] a, input logic [31:0] d);
    p0_req_valid = v; p0_req_we = we; p0_req_width = w; p0_req_addr = a; p0_req_wdata = d;
  endtask

  task automatic drive_p1(input logic v, input logic we, input logic [2:0] w, input logic [8:0] a, input logic [31:0] d);
    p1_req_valid = v; p1_req_we = we; p1_req_width = w; p1_req_addr = a; p1_req_wdata = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"},   32'({p1_req_ready, p0_req_ready}), 32'h0);
    check({tag, "_rv"},    32'({p1_resp_valid, p0_resp_valid}), 32'h0);
    check({tag, "_err"},   32'({p1_resp_err, p0_resp_err}), 32'h0);
    check({tag, "_rd0"},   p0_resp_rdata, 32'h0);
    check({tag, "_rd1"},   p1_resp_rdata, 32'h0);
    check({tag, "_strb"},  32'({mem_we, mem_re}), 32'h0);
    check({tag, "_maddr"}, 32'(mem_addr), 32'h0);
    check({tag, "_mwd"},   mem_wdata, 32'h0);
    check({tag, "_mws"},   32'(mem_width_sel), 32'h0);
  endtask

  int resp0_cnt, resp1_cnt;

  initial begin
    // Little-endian memory: SB 0x10=0x11, SB 0x11=0x22, SH 0x12=0x3344 puts
    // 0x44 at 0x12 and 0x33 at 0x13, so LW 0x010 reads 0x33442211.
    //   p0: v  we w       addr    wdata          p1: v  we w       addr    wdata          rdy    we  re  maddr   rv     err    rd0            rd1
    add(1, 1, WID_W, 9'h010, 32'hA5A50010, 0, 0, WID_B, 9'h000, 32'h0,      2'b01, 1, 0, 9'h010, 2'b00, 2'b00, 32'h0,         32'h0);
    add(1, 0, WID_W, 9'h010, 32'h0,        0, 0, WID_B, 9'h000, 32'h0,      2'b01, 0, 1, 9'h010, 2'b01, 2'b00, 32'h0,         32'h0);
    add(0, 0, WID_B, 9'h000, 32'h0,        0, 0, WID_B, 9'h000, 32'h0,      2'b00, 0, 0, 9'h010, 2'b01, 2'b00, 32'hA5A50010,  32'h0);
    add(0, 0, WID_B, 9'h000, 32'h0,        1, 1, WID_W, 9'h00C, 32'h44332211, 2'b10, 1, 0, 9'h00C, 2'b00, 2'b00, 32'h0,       32'h0);
    add(0, 0, WID_B, 9'h000, 32'h0,        1, 0, WID_B, 9'h00C, 32'h0,      2'b10, 0, 1, 9'h00C, 2'b10, 2'b00, 32'h0,         32'h0);
    add(0, 0, WID_B, 9'h000, 32'h0,        1, 0, WID_B, 9'h00D, 32'h0,      2'b10, 0, 1, 9'h00D, 2'b10, 2'b00, 32'h0,         32'h11);
    add(0, 0, WID_B, 9'h000, 32'h0,        1, 0, WID_B, 9'h00E, 32'h0,      2'b10, 0, 1, 9'h00E, 2'b10, 2'b00, 32'h0,         32'h22);
    add(0, 0, WID_B, 9'h000, 32'h0,        1, 0, WID_B, 9'h00F, 32'h0,      2'b10, 0, 1, 9'h00F, 2'b10, 2'b00, 32'h0,         32'h33);
    add(0, 0, WID_B, 9'h000, 32'h0,        0, 0, WID_B, 9'h000, 32'h0,      2'b00, 0, 0, 9'h00F, 2'b10, 2'b00, 32'h0,         32'h44);
    add(1, 0, WID_W, 9'h002, 32'h0,        0, 0, WID_B, 9'h000, 32'h0,      2'b01, 0, 0, 9'h00F, 2'b00, 2'b00, 32'h0,         32'h0);
    add(1, 1, WID_H, 9'h00D, 32'h1234,     0, 0, WID_B, 9'h000, 32'h0,      2'b01, 0, 0, 9'h00F, 2'b01, 2'b01, 32'h0,         32'h0);
    add(0, 0, WID_B, 9'h000, 32'h0,        1, 1, WID_BU, 9'h00C, 32'hFF,    2'b10, 0, 0, 9'h00F, 2'b01, 2'b01, 32'h0,         32'h0);
    add(0, 0, WID_B, 9'h000, 32'h0,        1, 0, WID_W, 9'h00C, 32'h0,      2'b10, 0, 1, 9'h00C, 2'b10, 2'b10, 32'h0,         32'h0);
    add(0, 0, WID_B, 9'h000, 32'h0,        0, 0, WID_B, 9'h000, 32'h0,      2'b00, 0, 0, 9'h00C, 2'b10, 2'b00, 32'h0,         32'h44332211);
    add(1, 1, WID_B, 9'h010, 32'h11,       0, 0, WID_B, 9'h000, 32'h0,      2'b01, 1, 0, 9'h010, 2'b00, 2'b00, 32'h0,         32'h0);
    add(1, 1, WID_B, 9'h011, 32'h22,       0, 0, WID_B, 9'h000, 32'h0,      2'b01, 1, 0, 9'h011, 2'b01, 2'b00, 32'h0,         32'h0);
    add(1, 1, WID_H, 9'h012, 32'h3344,     0, 0, WID_B, 9'h000, 32'h0,      2'b01, 1, 0, 9'h012, 2'b01, 2'b00, 32'h0,         32'h0);
    add(1, 0, WID_W, 9'h010, 32'h0,        0, 0, WID_B, 9'h000, 32'h0,      2'b01, 0, 1, 9'h010, 2'b01, 2'b00, 32'h0,         32'h0);
    add(0, 0, WID_B, 9'h000, 32'h0,        0, 0, WID_B, 9'h000, 32'h0,      2'b00, 0, 0, 9'h010, 2'b01, 2'b00, 32'h33442211,  32'h0);
    // last grant was p0, so p1 wins the first of two contended cycles
    add(1, 0, WID_W, 9'h00C, 32'h0,        1, 0, WID_BU, 9'h010, 32'h0,     2'b10, 0, 1, 9'h010, 2'b00, 2'b00, 32'h0,         32'h0);
    add(1, 0, WID_W, 9'h00C, 32'h0,        1, 0, WID_BU, 9'h010, 32'h0,     2'b01, 0, 1, 9'h00C, 2'b10, 2'b00, 32'h0,         32'h11);
    add(0, 0, WID_B, 9'h000, 32'h0,        0, 0, WID_B, 9'h000, 32'h0,      2'b00, 0, 0, 9'h00C, 2'b01, 2'b00, 32'h44332211,  32'h0);

    // ---- reset: outputs forced to 0 even with requests present ----
    rst = 1'b1;
    drive_p0(1, 0, WID_W, 9'h010, 32'h0);
    drive_p1(1, 1, WID_W, 9'h00C, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- table ----
    for (int i = 0; i < vt.size(); i++) begin
      drive_p0(vt[i].v0, vt[i].we0, vt[i].w0, vt[i].a0, vt[i].d0);
      drive_p1(vt[i].v1, vt[i].we1, vt[i].w1, vt[i].a1, vt[i].d1);
      @(negedge clk);
      check($sformatf("v%0d_rdy", i),   32'({p1_req_ready, p0_req_ready}), 32'(vt[i].rdy));
      check($sformatf("v%0d_strb", i),  32'({mem_we, mem_re}), 32'({vt[i].mwe, vt[i].mre}));
      check($sformatf("v%0d_maddr", i), 32'(mem_addr), 32'(vt[i].maddr));
      check($sformatf("v%0d_rv", i),    32'({p1_resp_valid, p0_resp_valid}), 32'(vt[i].rv));
      check($sformatf("v%0d_err", i),   32'({p1_resp_err, p0_resp_err}), 32'(vt[i].err));
      check($sformatf("v%0d_rd0", i),   p0_resp_rdata, vt[i].rd0);
      check($sformatf("v%0d_rd1", i),   p1_resp_rdata, vt[i].rd1);
      @(posedge clk); #1;
    end

    // ---- reset in the cycle after a p0 load accept ----
    drive_p0(1, 0, WID_W, 9'h010, 32'h0);
    drive_p1(0, 0, WID_B, 9'h000, 32'h0);
    @(negedge clk);
    check("mid_accept", 32'({p0_req_ready, mem_re}), 32'h3);
    @(posedge clk); #1;
    rst = 1'b1;
    drive_p0(0, 0, WID_B, 9'h000, 32'h0);
    @(negedge clk);
    check_all_zero("mid_rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rv", 32'({p1_resp_valid, p0_resp_valid}), 32'h0);
    @(posedge clk); #1;

    // ---- contention: six cycles, both ports, then one drain cycle ----
    resp0_cnt = 0;
    resp1_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      if (k < 6) begin
        drive_p0(1, 0, WID_W, 9'h010, 32'h0);
        drive_p1(1, 0, WID_W, 9'h00C, 32'h0);
      end else begin
        drive_p0(0, 0, WID_B, 9'h000, 32'h0);
        drive_p1(0, 0, WID_B, 9'h000, 32'h0);
      end
      @(negedge clk);
      if (k < 6)
        check($sformatf("cont%0d_gnt", k), 32'({p1_req_ready, p0_req_ready}), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) begin
        if ((k - 1) % 2 == 0) begin
          check($sformatf("cont%0d_rv", k), 32'({p1_resp_valid, p0_resp_valid}), 32'h1);
          check($sformatf("cont%0d_rd0", k), p0_resp_rdata, 32'h33442211);
        end else begin
          check($sformatf("cont%0d_rv", k), 32'({p1_resp_valid, p0_resp_valid}), 32'h2);
          check($sformatf("cont%0d_rd1", k), p1_resp_rdata, 32'h44332211);
        end
      end
      if (p0_resp_valid) resp0_cnt++;
      if (p1_resp_valid) resp1_cnt++;
      @(posedge clk); #1;
    end
    check("cont_resp0_cnt", 32'(resp0_cnt), 32'd3);
    check("cont_resp1_cnt", 32'(resp1_cnt), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
